// File: rtl/lmsm_sequencer_if.sv
// rtl/lmsm_sequencer_if.sv - controller <-> LM/SM sequencer handshake and address bundle
//
// Signals (directions shown for the slave / sequencer side):
//   start      in   begin a sequence (honoured in IDLE only)
//   next       in   current transfer complete, advance (honoured in XFER only)
//   reg_list   in   register list IR[7:0], latched on accepted start
//   base_addr  in   first memory address, latched on accepted start
//   reg_addr   out  register index of the current transfer
//   mem_addr   out  memory address of the current transfer
//   valid      out  reg_addr/mem_addr meaningful
//   busy       out  sequence in progress (XFER or DONE)
//   done       out  one-cycle end-of-sequence pulse
//   xfer_count out  transfers completed in the current or last sequence

interface lmsm_sequencer_if #(
    parameter int LIST_W = 8,
    parameter int ADDR_W = 16,
    parameter int RA_W   = 3
);
    logic              start;
    logic              next;
    logic [LIST_W-1:0] reg_list;
    logic [ADDR_W-1:0] base_addr;
    logic [RA_W-1:0]   reg_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic              valid;
    logic              busy;
    logic              done;
    logic [RA_W:0]     xfer_count;

    modport master (
        output start, next, reg_list, base_addr,
        input  reg_addr, mem_addr, valid, busy, done, xfer_count
    );

    modport slave (
        input  start, next, reg_list, base_addr,
        output reg_addr, mem_addr, valid, busy, done, xfer_count
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// rtl/lmsm_sequencer.sv - register-list sequencer for load-multiple / store-multiple
//
// Ports:
//   clk       processor clock, rising-edge sampled
//   proc_rst  asynchronous active-low reset
//   bus       lmsm_sequencer_if.slave: start/next/reg_list/base_addr in,
//             reg_addr/mem_addr/valid/busy/done/xfer_count out
//
// Visits the set bits of the latched register list in ascending order, one
// per next, pairing each with a post-incremented memory address.

module lmsm_sequencer #(
    parameter int LIST_W = 8,
    parameter int ADDR_W = 16,
    parameter int RA_W   = 3
) (
    input  logic               clk,
    input  logic               proc_rst,
    lmsm_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [LIST_W-1:0] mask, mask_nx;
    logic [ADDR_W-1:0] addr, addr_nx;
    logic [RA_W:0]     cnt, cnt_nx;

    logic [RA_W-1:0]   low_idx;
    logic [LIST_W-1:0] mask_cleared;

    // Priority encoder: scanning downward lets the lowest set bit win.
    always_comb begin
        low_idx = '0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = RA_W'(i);
            end
        end
    end

    // x & (x-1) drops exactly the lowest set bit.
    assign mask_cleared = mask & (mask - {{(LIST_W-1){1'b0}}, 1'b1});

    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            state <= S_IDLE;
            mask  <= '0;
            addr  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            mask  <= mask_nx;
            addr  <= addr_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        mask_nx        = mask;
        addr_nx        = addr;
        cnt_nx         = cnt;
        bus.valid      = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        bus.reg_addr   = '0;
        bus.mem_addr   = addr;
        bus.xfer_count = cnt;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    mask_nx  = bus.reg_list;
                    addr_nx  = bus.base_addr;
                    cnt_nx   = '0;
                    state_nx = (bus.reg_list == '0) ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                bus.valid    = 1'b1;
                bus.busy     = 1'b1;
                bus.reg_addr = low_idx;
                if (bus.next) begin
                    mask_nx = mask_cleared;
                    addr_nx = addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    cnt_nx  = cnt + {{RA_W{1'b0}}, 1'b1};
                    if (mask_cleared == '0) begin
                        state_nx = S_DONE;
                    end
                end
            end
            S_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/lmsm_sequencer.md
# lmsm_sequencer

Register-list sequencer for the multicycle processor's load-multiple / store-multiple (LM/SM, opcodes 6 and 7) instructions. It sits directly downstream of the controller. The controller issues a start pulse with the 8-bit register list (IR[7:0]) and the base address. The controller then steps the block once per memory transfer. The block supplies the register-file address and the memory address for each transfer, plus a done pulse, replacing the controller's free-running 3-bit counter.

## Interface
- LIST_W, 8: register-list width; one bit per architectural register.
- ADDR_W, 16: memory address width.
- RA_W, 3: register address width; equals log2(LIST_W).

Ports:
- clk, in, 1: processor clock; the block samples on the rising edge, and the controller drives on the falling edge.
- proc_rst, in, 1: reset; asynchronous, active-low.
- start, in, 1: begin a sequence; sampled only in IDLE.
- next, in, 1: current transfer is complete, advance; sampled only in XFER.
- reg_list, in, LIST_W: register list (IR[7:0]); latched on accepted start.
- base_addr, in, ADDR_W: first memory address (contents of Ra); latched on accepted start.
- reg_addr, out, RA_W: register index for the current transfer.
- mem_addr, out, ADDR_W: memory address for the current transfer.
- valid, out, 1: reg_addr and mem_addr are meaningful (state XFER).
- busy, out, 1: high in XFER and DONE.
- done, out, 1: one-cycle pulse at the end of a sequence.
- xfer_count, out, RA_W+1: number of transfers completed in the current or last sequence.

## Operation
- Registered state: an FSM, a remaining-mask register `mask` (LIST_W), an address register `addr` (ADDR_W), and `xfer_count`.
- States: IDLE, XFER, DONE.
- IDLE, on start=1:
  - Latch mask←reg_list, addr←base_addr, xfer_count←0.
  - If reg_list==0, go to DONE (zero transfers).
  - Otherwise, go to XFER.
- XFER:
  - valid=1.
  - reg_addr = index of the lowest set bit of mask. This is a combinational priority encoder; bit 0 has the highest priority, so registers are visited in ascending order.
  - mem_addr=addr.
- XFER, on next=1:
  - Clear the lowest set bit of mask.
  - addr←addr+1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
  - xfer_count←xfer_count+1.
  - If the cleared mask==0, go to DONE; otherwise stay in XFER.
- DONE: done=1 for exactly one cycle, then go unconditionally to IDLE. xfer_count holds until the next accepted start.
- Outputs outside XFER: reg_addr=0, mem_addr=addr (last value held), valid=0.
- Ignored inputs:
  - start in XFER or DONE (no restart, no relatch).
  - next in IDLE or DONE.
  - start and next asserted together in IDLE: start is accepted, next is ignored.
- The block does not drive memory or register-file enables. The controller gates the read/write strobes with valid.

## Timing
- Reset (proc_rst=0, asynchronous, takes effect immediately even mid-sequence):
  - FSM=IDLE, mask=0, addr=0, xfer_count=0.
  - valid=0, busy=0, done=0, reg_addr=0, mem_addr=0.
- Release of reset is synchronous to the next rising edge. start is honoured from the first rising edge after release.
- Start latency: start sampled at edge N gives valid=1, with the first reg_addr/mem_addr, from edge N (registered state) through the edge on which next is sampled.
- Per-transfer: next sampled at edge M presents the following register/address after edge M. There is one transfer per next, with no bubbles.
- For a list with K set bits (K≥1): done asserts in the cycle after the K-th next is sampled. Total time is K next-handshakes + 1 DONE cycle; busy is high throughout.
- For an empty list: done asserts in the cycle after start; valid never asserts; xfer_count=0.
- Maximum sequence: K=8, xfer_count reaches 8, which requires the 4-bit width.
- next may be held high continuously; the block then advances one register per cycle.

## Test plan
- Reset/idle:
  - Stimulus: assert proc_rst=0 mid-cycle.
  - Required: all outputs 0 immediately; no valid until start after release.
- Full list:
  - Stimulus: reg_list=0xFF, base_addr=0x0100, next held high.
  - Required: reg_addr 0,1,…,7 paired with mem_addr 0x0100…0x0107 on consecutive cycles; done one cycle after the 8th transfer; xfer_count=8.
- Sparse list with stalls:
  - Stimulus: reg_list=0xA4, base_addr=0x2000; next pulsed every 3 cycles.
  - Required: pairs (2,0x2000), (5,0x2001), (7,0x2002), each held stable between next pulses; xfer_count=3.
- Empty list:
  - Stimulus: reg_list=0x00 with start.
  - Required: valid never asserts; done pulses in the cycle after start; xfer_count=0; back in IDLE the cycle after that.
- Wrap and ignored inputs:
  - Stimulus: reg_list=0x03, base_addr=0xFFFF; also start asserted during XFER with reg_list=0xF0.
  - Required: mem_addr 0xFFFF then 0x0000; registers 0,1 only (the second start is ignored).
- Reset mid-operation:
  - Stimulus: reg_list=0x0F; assert reset after 2 transfers, then start with reg_list=0x10, base_addr=0x0040.
  - Required: outputs clear at reset; the new sequence gives the single transfer (4,0x0040); xfer_count=1.
